// File: rtl/rvv_alu_seq.sv
// Vector ALU lane sequencer: walks an operation one lane chunk per cycle
// and collects the lane results into a destination image for write-back.
module rvv_alu_seq #(
    parameter int VLEN       = 128,
    parameter int LANE_WIDTH = 3
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [9:0]      vl,
    input  logic [2:0]      vsew,
    input  logic [VLEN-1:0] vd_init,
    output logic            busy,
    output logic            alu_run,
    output logic [9:0]      alu_index,
    output logic [3:0]      alu_in_reg_offset,
    input  logic [63:0]     alu_vd,
    output logic            res_valid,
    input  logic            res_ready,
    output logic [VLEN-1:0] res_vd,
    output logic            res_err
);

    localparam int LW = 1 << LANE_WIDTH;
    localparam logic [4:0] LANE_LOG = 5'(LANE_WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DONE
    } state_t;

    state_t state_q, state_d;

    logic [9:0]      c_q;
    logic [3:0]      o_q;
    logic [3:0]      cpe_m1_q;
    logic [9:0]      last_q;
    logic            err_q;
    logic [VLEN-1:0] vd_q;

    logic [4:0]  sew_log;
    logic [4:0]  shamt;
    logic [19:0] op_bits;
    logic [14:0] n_chunks;
    logic        start_err;
    logic        start_zero;
    logic [9:0]  chunk_bit;
    logic        unused_alu;

    // Operation decode straight from the request inputs; only the
    // derived values latched at start are used afterwards.
    assign sew_log  = 5'(vsew) + 5'd3;
    assign shamt    = sew_log - LANE_LOG;
    assign op_bits  = 20'(vl) << sew_log;
    assign n_chunks = 15'(vl) << shamt;

    assign start_err = (vsew > 3'd3)
                     || (sew_log < LANE_LOG)
                     || (shamt > 5'd4)
                     || (op_bits > 20'(VLEN));
    assign start_zero = (vl == 10'd0);

    assign chunk_bit  = c_q << LANE_WIDTH;
    assign unused_alu = ^alu_vd;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d           = state_q;
        busy              = 1'b0;
        alu_run           = 1'b0;
        alu_index         = '0;
        alu_in_reg_offset = '0;
        res_valid         = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (start_err || start_zero) begin
                        state_d = DONE;
                    end else begin
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                busy              = 1'b1;
                alu_run           = 1'b1;
                alu_index         = chunk_bit;
                alu_in_reg_offset = o_q;
                if (c_q == last_q) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                res_valid = 1'b1;
                if (res_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            c_q      <= '0;
            o_q      <= '0;
            cpe_m1_q <= '0;
            last_q   <= '0;
            err_q    <= 1'b0;
            vd_q     <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        vd_q     <= vd_init;
                        err_q    <= start_err;
                        c_q      <= '0;
                        o_q      <= '0;
                        cpe_m1_q <= 4'((5'd1 << shamt) - 5'd1);
                        last_q   <= 10'(n_chunks - 15'd1);
                    end
                end
                ISSUE: begin
                    // Lane is combinational: capture in the issue cycle.
                    vd_q[chunk_bit +: LW] <= alu_vd[LW-1:0];
                    c_q <= c_q + 10'd1;
                    if (o_q == cpe_m1_q) begin
                        o_q <= '0;
                    end else begin
                        o_q <= o_q + 4'd1;
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        err_q <= 1'b0;
                    end
                end
                default: begin
                    err_q <= 1'b0;
                end
            endcase
        end
    end

    assign res_vd  = vd_q;
    assign res_err = err_q;

endmodule

// File: tb/tb_rvv_alu_seq.sv
// Directed bench for rvv_alu_seq with a small byte-lane ALU model
// (index+1 mode and carry-chained add mode).
module tb_rvv_alu_seq;

    localparam int VLEN       = 128;
    localparam int LANE_WIDTH = 3;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            start = 1'b0;
    logic [9:0]      vl = '0;
    logic [2:0]      vsew = '0;
    logic [VLEN-1:0] vd_init = '0;
    logic            busy;
    logic            alu_run;
    logic [9:0]      alu_index;
    logic [3:0]      alu_in_reg_offset;
    logic [63:0]     alu_vd;
    logic            res_valid;
    logic            res_ready = 1'b0;
    logic [VLEN-1:0] res_vd;
    logic            res_err;

    int n_cmp = 0;
    int n_bad = 0;

    logic         mode = 1'b0;
    logic [127:0] vs1 = '0;
    logic [127:0] vs2 = '0;
    logic         cout_q = 1'b0;
    logic         cin;
    logic [8:0]   sum;

    int          nrun;
    int          lat;
    logic [9:0]  idx_log[64];
    logic [3:0]  off_log[64];
    logic        cq_log[64];

    rvv_alu_seq #(
        .VLEN(VLEN),
        .LANE_WIDTH(LANE_WIDTH)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .vl(vl),
        .vsew(vsew),
        .vd_init(vd_init),
        .busy(busy),
        .alu_run(alu_run),
        .alu_index(alu_index),
        .alu_in_reg_offset(alu_in_reg_offset),
        .alu_vd(alu_vd),
        .res_valid(res_valid),
        .res_ready(res_ready),
        .res_vd(res_vd),
        .res_err(res_err)
    );

    always #5 clk = ~clk;

    always_comb begin
        cin = (alu_in_reg_offset == 4'd0) ? 1'b0 : cout_q;
        sum = {1'b0, vs1[alu_index +: 8]} + {1'b0, vs2[alu_index +: 8]}
            + 9'(cin);
        alu_vd = mode ? {56'd0, sum[7:0]} : (64'(alu_index) + 64'd1);
    end

    always_ff @(posedge clk) begin
        cout_q <= alu_run ? sum[8] : 1'b0;
    end

    task automatic do_op(input logic [9:0] v, input logic [2:0] s,
                         input logic [127:0] init);
        vl = v;
        vsew = s;
        vd_init = init;
        start = 1'b1;
        nrun = 0;
        lat = 0;
        for (int cyc = 1; cyc <= 300; cyc++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            vl = 10'h3ff;
            vsew = 3'd7;
            vd_init = '0;
            if (alu_run) begin
                if (nrun < 64) begin
                    idx_log[nrun] = alu_index;
                    off_log[nrun] = alu_in_reg_offset;
                    cq_log[nrun] = cout_q;
                end
                nrun++;
            end
            if (res_valid) begin
                lat = cyc;
                break;
            end
        end
    endtask

    task automatic accept();
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        res_ready = 1'b0;
    endtask

    task automatic test_reset();
        logic [VLEN-1:0] ones;
        ones = '1;
        n_cmp++;
        if ({busy, alu_run, alu_index, alu_in_reg_offset,
             res_valid, res_err} !== 18'd0) begin
            n_bad++;
            $display("FAIL reset_ctrl got %h want 0",
                     {busy, alu_run, alu_index, alu_in_reg_offset,
                      res_valid, res_err});
        end
        n_cmp++;
        if (res_vd !== '0) begin
            n_bad++;
            $display("FAIL reset_vd got %h want 0", res_vd);
        end
        reset = 1'b0;
        @(posedge clk);
        #1;
        mode = 1'b0;
        vl = 10'd2;
        vsew = 3'd2;
        vd_init = ones;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        n_cmp++;
        if ({alu_run, alu_index} !== {1'b1, 10'd16}) begin
            n_bad++;
            $display("FAIL pre_reset_issue got %h want %h",
                     {alu_run, alu_index}, {1'b1, 10'd16});
        end
        #2;
        reset = 1'b1;
        #1;
        n_cmp++;
        if ({busy, alu_run, alu_index, alu_in_reg_offset,
             res_valid, res_err} !== 18'd0) begin
            n_bad++;
            $display("FAIL midop_reset_ctrl got %h want 0",
                     {busy, alu_run, alu_index, alu_in_reg_offset,
                      res_valid, res_err});
        end
        n_cmp++;
        if (res_vd !== '0) begin
            n_bad++;
            $display("FAIL midop_reset_vd got %h want 0", res_vd);
        end
        #2;
        reset = 1'b0;
        @(posedge clk);
        #1;
        do_op(10'd4, 3'd0, ones);
        n_cmp++;
        if (lat !== 5) begin
            n_bad++;
            $display("FAIL post_reset_lat got %0d want 5", lat);
        end
        n_cmp++;
        if (res_vd !== {ones[127:32], 32'h19110901}) begin
            n_bad++;
            $display("FAIL post_reset_vd got %h want %h", res_vd,
                     {ones[127:32], 32'h19110901});
        end
        accept();
    endtask

    task automatic test_sew8();
        logic [VLEN-1:0] ones;
        ones = '1;
        mode = 1'b0;
        do_op(10'd4, 3'd0, ones);
        n_cmp++;
        if (nrun !== 4) begin
            n_bad++;
            $display("FAIL sew8_nrun got %0d want 4", nrun);
        end
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if ({idx_log[i], off_log[i]} !== {10'(8 * i), 4'd0}) begin
                n_bad++;
                $display("FAIL sew8_chunk%0d got %h want %h", i,
                         {idx_log[i], off_log[i]}, {10'(8 * i), 4'd0});
            end
        end
        n_cmp++;
        if (res_vd[31:0] !== 32'h19110901) begin
            n_bad++;
            $display("FAIL sew8_low got %h want 19110901", res_vd[31:0]);
        end
        n_cmp++;
        if (res_vd[127:32] !== ones[127:32]) begin
            n_bad++;
            $display("FAIL sew8_tail got %h want all ones",
                     res_vd[127:32]);
        end
        n_cmp++;
        if ({lat, res_err} !== {32'd5, 1'b0}) begin
            n_bad++;
            $display("FAIL sew8_lat_err got %0d/%b want 5/0", lat,
                     res_err);
        end
        accept();
    endtask

    task automatic test_sew32();
        logic [127:0] init;
        init = {64'hDEADBEEF_CAFEF00D, 64'h0};
        mode = 1'b0;
        do_op(10'd2, 3'd2, init);
        n_cmp++;
        if (nrun !== 8) begin
            n_bad++;
            $display("FAIL sew32_nrun got %0d want 8", nrun);
        end
        for (int i = 0; i < 8; i++) begin
            n_cmp++;
            if ({idx_log[i], off_log[i]} !== {10'(8 * i), 4'(i % 4)}) begin
                n_bad++;
                $display("FAIL sew32_chunk%0d got %h want %h", i,
                         {idx_log[i], off_log[i]},
                         {10'(8 * i), 4'(i % 4)});
            end
        end
        n_cmp++;
        if (res_vd !== {64'hDEADBEEF_CAFEF00D, 64'h39312921_19110901})
        begin
            n_bad++;
            $display("FAIL sew32_vd got %h want %h", res_vd,
                     {64'hDEADBEEF_CAFEF00D, 64'h39312921_19110901});
        end
        n_cmp++;
        if (lat !== 9) begin
            n_bad++;
            $display("FAIL sew32_lat got %0d want 9", lat);
        end
        accept();
    endtask

    task automatic test_full_width();
        logic [127:0] exp_vd;
        for (int i = 0; i < 16; i++) begin
            exp_vd[8 * i +: 8] = 8'(8 * i + 1);
        end
        mode = 1'b0;
        do_op(10'd2, 3'd3, '0);
        n_cmp++;
        if ({nrun, lat, res_err} !== {32'd16, 32'd17, 1'b0}) begin
            n_bad++;
            $display("FAIL full_cnt got %0d/%0d/%b want 16/17/0", nrun,
                     lat, res_err);
        end
        n_cmp++;
        if ({off_log[7], off_log[8], off_log[15]} !== {4'd7, 4'd0, 4'd7})
        begin
            n_bad++;
            $display("FAIL full_off got %h want 707",
                     {off_log[7], off_log[8], off_log[15]});
        end
        n_cmp++;
        if (res_vd !== exp_vd) begin
            n_bad++;
            $display("FAIL full_vd got %h want %h", res_vd, exp_vd);
        end
        accept();
    endtask

    task automatic test_zero_err();
        logic [127:0] init;
        init = 128'h01234567_89ABCDEF_FEDCBA98_76543210;
        mode = 1'b0;
        do_op(10'd0, 3'd0, init);
        n_cmp++;
        if ({nrun, lat, res_err} !== {32'd0, 32'd1, 1'b0}) begin
            n_bad++;
            $display("FAIL zero_cnt got %0d/%0d/%b want 0/1/0", nrun, lat,
                     res_err);
        end
        n_cmp++;
        if (res_vd !== init) begin
            n_bad++;
            $display("FAIL zero_vd got %h want %h", res_vd, init);
        end
        accept();
        do_op(10'd3, 3'd3, init);
        n_cmp++;
        if ({nrun, lat, res_err} !== {32'd0, 32'd1, 1'b1}) begin
            n_bad++;
            $display("FAIL ovf_cnt got %0d/%0d/%b want 0/1/1", nrun, lat,
                     res_err);
        end
        n_cmp++;
        if (res_vd !== init) begin
            n_bad++;
            $display("FAIL ovf_vd got %h want %h", res_vd, init);
        end
        accept();
        n_cmp++;
        if ({res_err, busy} !== 2'b00) begin
            n_bad++;
            $display("FAIL err_clear got %b want 00", {res_err, busy});
        end
        do_op(10'd1, 3'd4, init);
        n_cmp++;
        if ({nrun, res_err} !== {32'd0, 1'b1}) begin
            n_bad++;
            $display("FAIL sew4_err got %0d/%b want 0/1", nrun, res_err);
        end
        accept();
    endtask

    task automatic test_backpressure();
        logic [VLEN-1:0] ones;
        logic [VLEN-1:0] exp_vd;
        ones = '1;
        exp_vd = {ones[127:16], 16'h0901};
        mode = 1'b0;
        do_op(10'd2, 3'd0, ones);
        for (int k = 0; k < 5; k++) begin
            if (k == 2) begin
                start = 1'b1;
                vl = 10'd1;
                vsew = 3'd0;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            n_cmp++;
            if ({res_valid, alu_run, alu_index, alu_in_reg_offset}
                !== 16'h8000 || res_vd !== exp_vd) begin
                n_bad++;
                $display("FAIL stall%0d got %h/%h want 8000/%h", k,
                         {res_valid, alu_run, alu_index,
                          alu_in_reg_offset}, res_vd, exp_vd);
            end
        end
        accept();
        n_cmp++;
        if ({res_valid, busy} !== 2'b00 || res_vd !== exp_vd) begin
            n_bad++;
            $display("FAIL stall_release got %b/%h want 00/%h",
                     {res_valid, busy}, res_vd, exp_vd);
        end
    endtask

    task automatic test_back_to_back();
        logic [VLEN-1:0] ones;
        ones = '1;
        mode = 1'b1;
        vs1 = {96'd0, 32'hFF00_00FF};
        vs2 = {96'd0, 32'h0100_0001};
        do_op(10'd2, 3'd1, '0);
        n_cmp++;
        if (res_vd !== {96'd0, 32'h0000_0100}) begin
            n_bad++;
            $display("FAIL add_vd got %h want 100", res_vd);
        end
        n_cmp++;
        if ({off_log[0], off_log[1], off_log[2], off_log[3]} !== 16'h0101)
        begin
            n_bad++;
            $display("FAIL add_off got %h want 0101",
                     {off_log[0], off_log[1], off_log[2], off_log[3]});
        end
        accept();
        n_cmp++;
        if (res_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL one_valid got %b want 0", res_valid);
        end
        vs1 = {96'd0, 32'h0000_0001};
        vs2 = {96'd0, 32'h0000_0001};
        do_op(10'd1, 3'd1, ones);
        n_cmp++;
        if ({nrun, lat, cq_log[0]} !== {32'd2, 32'd3, 1'b0}) begin
            n_bad++;
            $display("FAIL b2b_cnt got %0d/%0d/%b want 2/3/0", nrun, lat,
                     cq_log[0]);
        end
        n_cmp++;
        if (res_vd !== {ones[127:16], 16'h0002}) begin
            n_bad++;
            $display("FAIL b2b_vd got %h want %h", res_vd,
                     {ones[127:16], 16'h0002});
        end
        accept();
    endtask

    initial begin
        #1;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_sew8();
        test_sew32();
        test_full_width();
        test_zero_err();
        test_backpressure();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp,
                 n_bad);
        $finish;
    end

endmodule
